float_mul_requester: RTL and testbench
======================================

# float_mul_requester

Initiator-side controller for the `float_mul_pipeline` req/ack handshake. It accepts operand pairs from an upstream valid/ready stream and issues each pair to the multiplier as a single-cycle `req`, holding operands stable until `ack`. It captures `out` and returns the product, with a measured latency, on a downstream valid/ready stream. It sits between the FPU dispatch logic in the core and the float multiplier.

## Interface
- `FLOAT_WIDTH`, 32, operand/result width (IEEE-754 single).
- `CNT_WIDTH`, 8, width of the latency counter.
- `TIMEOUT`, 100, cycles from `mul_req` to declared timeout; used only with the timeout macro; must be ≥ 3 and < 2^CNT_WIDTH.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: upstream operand pair valid.
- `in_ready` out 1: block can accept a pair this cycle.
- `in_a`, `in_b` in FLOAT_WIDTH: operands.
- `mul_req` out 1: single-cycle request pulse to the multiplier.
- `mul_a`, `mul_b` out FLOAT_WIDTH: operands to the multiplier, held from the `mul_req` cycle through the `mul_ack` cycle.
- `mul_ack` in 1: single-cycle completion pulse; `mul_out` is valid in the same cycle.
- `mul_out` in FLOAT_WIDTH: product from the multiplier.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts the result.
- `res_out` out FLOAT_WIDTH: captured product.
- `res_cycles` out CNT_WIDTH: number of cycles from the `mul_req` cycle to the `mul_ack` cycle, saturating.
- `res_err` out 1: result is a timeout, not a product.
- `stray_ack` out 1: sticky flag, set by any `mul_ack` seen outside WAIT.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch `in_a`/`in_b` into `mul_a`/`mul_b` and go to ISSUE.
- ISSUE: `mul_req`=1 for exactly this cycle. Latency counter loads 1. Go to WAIT.
- WAIT: counter increments each cycle and saturates at all-ones.
  - On `mul_ack`: `res_out`←`mul_out`, `res_cycles`←counter, `res_err`←0. Go to DONE.
- DONE: `res_valid`=1. `res_out`, `res_cycles` and `res_err` are held stable until `res_valid && res_ready`.
  - On handshake with `in_valid`=0: go to IDLE.
  - `in_ready` = `res_ready` in DONE. Handshake with `in_valid`=1 latches the new pair and goes straight to ISSUE, so back-to-back transfers have no bubble.
- `mul_a`/`mul_b` change only on an input handshake.
- `mul_ack` in IDLE, ISSUE or DONE is ignored for data and sets `stray_ack`. Only reset clears `stray_ack`.
- No arithmetic on operands. The block is transparent to sign, zero and NaN encodings.

## Timing
- Reset values: `in_ready`=0 while `rst` is low, then 1 in IDLE. `mul_req`=0. `mul_a`=`mul_b`=0. `res_valid`=0. `res_out`=0. `res_cycles`=0. `res_err`=0. `stray_ack`=0. State is IDLE.
- Input handshake at cycle C → `mul_req` high at C+1 (call it R).
- `mul_ack` at R+k → `res_valid` high at R+k+1 with `res_cycles`=k. The multiplier's zero-operand path gives k=2.
- Minimum input-to-result latency is 4 cycles when k=2.
- Reset asserted mid-operation: all state clears immediately. A later `mul_ack` from the still-busy multiplier arrives in IDLE and sets `stray_ack`.

## Configuration
- `FLOAT_MUL_REQ_TIMEOUT_EN` defined:
  - In WAIT, if no `mul_ack` has arrived by cycle R+TIMEOUT, go to DONE with `res_err`=1, `res_out`=0, `res_cycles`=TIMEOUT.
  - If `mul_ack` arrives exactly at R+TIMEOUT, the ack wins and the result is a normal product.
  - A late ack after timeout sets `stray_ack`.
- Not defined: WAIT has no exit other than `mul_ack`, and `res_err` is constant 0.

## Test plan
- 0.0×1.0 against the real multiplier → `res_out`=0x00000000, `res_cycles`=2, `res_err`=0. `mul_req` is high for exactly one cycle.
- 1.0×1.0, 1.1×1.1, −2000.0×2.3 → `res_out`=0x3F800000, ≈1.21 within tolerance, 0xC58FC000 respectively. `mul_a`/`mul_b` are stable from R through the ack cycle.
- `res_ready` held low for 5 cycles after 2.0×2.0 → `res_out`=0x40800000 stable, `in_ready`=0, no second `mul_req`. Then `res_ready`=1 with `in_valid`=1 (8.0×4.0) → next `mul_req` in the following cycle, with 0x42000000 returned.
- Stub multiplier that never acks, macro on, TIMEOUT=100 → `res_valid` at R+101 with `res_err`=1 and `res_cycles`=100. Ack injected 10 cycles later → `stray_ack`=1, `res_out` unchanged.
- Same stub with ack injected at exactly R+100 → normal result, `res_err`=0.
- `rst` pulsed low during WAIT of 11.0×11.0 → all outputs return to reset values asynchronously. The subsequent multiplier ack sets `stray_ack`. The next request, 10.0×4.0, returns 0x42200000.

Source files
------------

// File: rtl/float_mul_requester.sv
// Initiator for the float multiplier req/ack handshake: takes operand pairs, pulses mul_req, returns product and latency.
// Latency: input handshake to mul_req is 1 cycle; mul_ack at R+k gives res_valid at R+k+1 (4 cycles minimum for k=2).
// Backpressure: in_ready is high only in IDLE or in DONE while res_ready is high; result held stable until accepted.
// Optional feature macro: FLOAT_MUL_REQ_TIMEOUT_EN (WAIT gives up after TIMEOUT cycles with res_err=1).
module float_mul_requester #(
  parameter int FLOAT_WIDTH = 32,
  parameter int CNT_WIDTH   = 8,
  parameter int TIMEOUT     = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in_a,
  input  logic [FLOAT_WIDTH-1:0] in_b,
  output logic                   mul_req,
  output logic [FLOAT_WIDTH-1:0] mul_a,
  output logic [FLOAT_WIDTH-1:0] mul_b,
  input  logic                   mul_ack,
  input  logic [FLOAT_WIDTH-1:0] mul_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FLOAT_WIDTH-1:0] res_out,
  output logic [CNT_WIDTH-1:0]   res_cycles,
  output logic                   res_err,
  output logic                   stray_ack
);

  // The timeout value must fit the counter and leave room for the shortest ack path.
  if (TIMEOUT < 3 || TIMEOUT >= (2 ** CNT_WIDTH)) begin : g_bad_timeout
    $error("float_mul_requester: TIMEOUT out of range for CNT_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [FLOAT_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [FLOAT_WIDTH-1:0] mul_b_q, mul_b_d;
  logic                   mul_req_q, mul_req_d;
  logic                   idle_rdy_q, idle_rdy_d;
  logic                   res_valid_q, res_valid_d;
  logic [FLOAT_WIDTH-1:0] res_out_q, res_out_d;
  logic [CNT_WIDTH-1:0]   res_cycles_q, res_cycles_d;
  logic                   res_err_q, res_err_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stray_q, stray_d;
  logic                   in_fire;

  // idle_rdy_q is a registered copy of "in IDLE" so in_ready stays low throughout reset.
  assign in_ready = idle_rdy_q | ((state_q == DONE) & res_ready);
  assign in_fire  = in_valid & in_ready;

  // Next-state and datapath: operand latch, latency count, result capture, stray-ack detection.
  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_req_d    = 1'b0;
    res_valid_d  = res_valid_q;
    res_out_d    = res_out_q;
    res_cycles_d = res_cycles_q;
    res_err_d    = res_err_q;
    cnt_d        = cnt_q;
    stray_d      = stray_q;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          mul_a_d   = in_a;
          mul_b_d   = in_b;
          mul_req_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // The request cycle itself counts as the first cycle of latency.
        cnt_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_ack) begin
          res_out_d    = mul_out;
          res_cycles_d = cnt_q;
          res_err_d    = 1'b0;
          res_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef FLOAT_MUL_REQ_TIMEOUT_EN
          // cnt_q equals TIMEOUT during cycle R+TIMEOUT; an ack in that same cycle wins above.
          if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
            res_out_d    = '0;
            res_cycles_d = CNT_WIDTH'(TIMEOUT);
            res_err_d    = 1'b1;
            res_valid_d  = 1'b1;
            state_d      = DONE;
          end
`endif
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (in_valid) begin
            // Accept the next pair in the same cycle the result leaves: no bubble.
            mul_a_d   = in_a;
            mul_b_d   = in_b;
            mul_req_d = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (mul_ack && (state_q != WAIT)) begin
      stray_d = 1'b1;
    end

    idle_rdy_d = (state_d == IDLE);
  end

  // All state and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_req_q    <= 1'b0;
      idle_rdy_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_out_q    <= '0;
      res_cycles_q <= '0;
      res_err_q    <= 1'b0;
      cnt_q        <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_req_q    <= mul_req_d;
      idle_rdy_q   <= idle_rdy_d;
      res_valid_q  <= res_valid_d;
      res_out_q    <= res_out_d;
      res_cycles_q <= res_cycles_d;
      res_err_q    <= res_err_d;
      cnt_q        <= cnt_d;
      stray_q      <= stray_d;
    end
  end

  assign mul_req    = mul_req_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign res_valid  = res_valid_q;
  assign res_out    = res_out_q;
  assign res_cycles = res_cycles_q;
  assign res_err    = res_err_q;
  assign stray_ack  = stray_q;

endmodule

// File: tb/tb_float_mul_requester.sv
// Directed and randomized bench for float_mul_requester; the bench itself plays the multiplier.
// Expected results come from a queue-based model: product passes through, latency = ack delay (saturating).
// Timeout scenarios run only when FLOAT_MUL_REQ_TIMEOUT_EN is defined; otherwise counter saturation is exercised.
module tb_float_mul_requester;

  localparam int FW  = 32;
  localparam int CW  = 8;
  localparam int TO  = 100;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_a;
  logic [FW-1:0] in_b;
  logic          mul_req;
  logic [FW-1:0] mul_a;
  logic [FW-1:0] mul_b;
  logic          mul_ack;
  logic [FW-1:0] mul_out;
  logic          res_valid;
  logic          res_ready;
  logic [FW-1:0] res_out;
  logic [CW-1:0] res_cycles;
  logic          res_err;
  logic          stray_ack;

  float_mul_requester #(.FLOAT_WIDTH(FW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .res_cycles(res_cycles), .res_err(res_err), .stray_ack(stray_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [FW-1:0] cur_a, cur_b;
  logic [FW-1:0] exp_out_q[$];
  int            exp_cyc_q[$];
  logic [FW-1:0] last_out;
  int            last_cyc;
  logic          exp_stray;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a pair from IDLE and confirm the request pulse follows one cycle later.
  task automatic start(input logic [FW-1:0] a, input logic [FW-1:0] b);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    cur_a    = a;
    cur_b    = b;
    chk("mul_req_rise", {31'b0, mul_req}, 32'd1);
    chk("mul_a_latch", mul_a, a);
    chk("mul_b_latch", mul_b, b);
  endtask

  // Act as the multiplier: ack k cycles after the request cycle, then check the returned result.
  task automatic respond(input logic [FW-1:0] prod, input int k);
    for (int j = 1; j <= k; j++) begin
      tick();
      chk("mul_req_single", {31'b0, mul_req}, 32'd0);
      chk("mul_a_stable", mul_a, cur_a);
      chk("mul_b_stable", mul_b, cur_b);
      chk("res_valid_early", {31'b0, res_valid}, 32'd0);
      if (j == k) begin
        mul_ack = 1'b1;
        mul_out = prod;
      end
    end
    tick();
    mul_ack = 1'b0;
    mul_out = $urandom;
    exp_out_q.push_back(prod);
    exp_cyc_q.push_back((k > 255) ? 255 : k);
    last_out = exp_out_q.pop_front();
    last_cyc = exp_cyc_q.pop_front();
    chk("res_valid", {31'b0, res_valid}, 32'd1);
    chk("res_out", res_out, last_out);
    chk("res_cycles", {24'b0, res_cycles}, last_cyc);
    chk("res_err", {31'b0, res_err}, 32'd0);
    chk("stray_ack", {31'b0, stray_ack}, {31'b0, exp_stray});
  endtask

  // Hold the result under backpressure and check it does not move.
  task automatic hold(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      chk("hold_out", res_out, last_out);
      chk("hold_cycles", {24'b0, res_cycles}, last_cyc);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_no_req", {31'b0, mul_req}, 32'd0);
    end
  endtask

  task automatic drain;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("drain_valid", {31'b0, res_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    mul_ack   = 1'b0;
    mul_out   = '0;
    res_ready = 1'b0;
    exp_stray = 1'b0;
    cur_a     = '0;
    cur_b     = '0;
    last_out  = '0;
    last_cyc  = 0;

    // Reset values
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mul_req", {31'b0, mul_req}, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_out", res_out, 32'd0);
    chk("rst_res_cycles", {24'b0, res_cycles}, 32'd0);
    chk("rst_res_err", {31'b0, res_err}, 32'd0);
    chk("rst_stray", {31'b0, stray_ack}, 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // 0.0 x 1.0 via the zero-operand path (k=2)
    start(32'h0000_0000, 32'h3F80_0000);
    respond(32'h0000_0000, 2);
    drain();

    // 1.0 x 1.0, 1.1 x 1.1, -2000.0 x 2.3
    start(32'h3F80_0000, 32'h3F80_0000);
    respond(32'h3F80_0000, 3);
    drain();
    start(32'h3F8C_CCCD, 32'h3F8C_CCCD);
    respond(32'h3F9A_E148, 4);
    drain();
    start(32'hC4FA_0000, 32'h4013_3333);
    respond(32'hC58F_C000, 5);
    drain();

    // Backpressure on 2.0 x 2.0 while 8.0 x 4.0 waits, then bubble-free hand-over
    start(32'h4000_0000, 32'h4000_0000);
    respond(32'h4080_0000, 2);
    in_valid = 1'b1;
    in_a     = 32'h4100_0000;
    in_b     = 32'h4080_0000;
    hold(5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    cur_a     = 32'h4100_0000;
    cur_b     = 32'h4080_0000;
    chk("b2b_mul_req", {31'b0, mul_req}, 32'd1);
    chk("b2b_mul_a", mul_a, cur_a);
    chk("b2b_mul_b", mul_b, cur_b);
    chk("b2b_valid_low", {31'b0, res_valid}, 32'd0);
    respond(32'h4200_0000, 2);
    drain();

    // Shortest possible WAIT (ack in the first WAIT cycle)
    start(32'h1234_5678, 32'h9ABC_DEF0);
    respond(32'h0BAD_F00D, 1);
    drain();

`ifdef FLOAT_MUL_REQ_TIMEOUT_EN
    // No ack: timeout result at R+TO+1, then a late ack is stray
    start(32'h4040_0000, 32'h4040_0000);
    for (int j = 1; j <= TO; j++) begin
      tick();
      chk("to_wait_valid", {31'b0, res_valid}, 32'd0);
      chk("to_wait_req", {31'b0, mul_req}, 32'd0);
    end
    tick();
    chk("to_valid", {31'b0, res_valid}, 32'd1);
    chk("to_err", {31'b0, res_err}, 32'd1);
    chk("to_cycles", {24'b0, res_cycles}, TO);
    chk("to_out", res_out, 32'd0);
    for (int j = 0; j < 10; j++) tick();
    mul_ack = 1'b1;
    mul_out = 32'h4110_0000;
    tick();
    mul_ack   = 1'b0;
    exp_stray = 1'b1;
    chk("late_ack_stray", {31'b0, stray_ack}, 32'd1);
    chk("late_ack_out", res_out, 32'd0);
    chk("late_ack_err", {31'b0, res_err}, 32'd1);
    drain();

    // Ack exactly at R+TO beats the timeout
    start(32'h4049_0FDB, 32'h3F80_0000);
    respond(32'h4049_0FDB, TO);
    drain();
`else
    // No timeout: long wait, counter saturates at all-ones
    start(32'h4040_0000, 32'h4040_0000);
    respond(32'h4110_0000, 300);
    drain();
`endif

    // Randomized transactions against the queue model
    for (int t = 0; t < 20; t++) begin
      logic [FW-1:0] ra, rb, rp;
      int            rk, rh;
      ra = $urandom;
      rb = $urandom;
      rp = $urandom;
      rk = $urandom_range(1, 12);
      rh = $urandom_range(0, 3);
      start(ra, rb);
      respond(rp, rk);
      hold(rh);
      drain();
    end

    // Asynchronous reset during WAIT of 11.0 x 11.0
    start(32'h4130_0000, 32'h4130_0000);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    exp_stray = 1'b0;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("arst_mul_req", {31'b0, mul_req}, 32'd0);
    chk("arst_mul_a", mul_a, 32'd0);
    chk("arst_mul_b", mul_b, 32'd0);
    chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_res_out", res_out, 32'd0);
    chk("arst_res_cycles", {24'b0, res_cycles}, 32'd0);
    chk("arst_res_err", {31'b0, res_err}, 32'd0);
    chk("arst_stray", {31'b0, stray_ack}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle_ready", {31'b0, in_ready}, 32'd1);
    mul_ack = 1'b1;
    mul_out = 32'h42F2_0000;
    tick();
    mul_ack   = 1'b0;
    exp_stray = 1'b1;
    chk("arst_late_stray", {31'b0, stray_ack}, 32'd1);
    chk("arst_late_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_late_req", {31'b0, mul_req}, 32'd0);
    start(32'h4120_0000, 32'h4080_0000);
    respond(32'h4220_0000, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
